// File: rtl/drfm_stream_pkg.sv
// Shared types for the DRFM stream arbiter slice.
// Arbiter states, tag-width helper and beat tag bundle.
package drfm_stream_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                last;
    logic [MAX_CH_W-1:0] ch;
  } beat_tag_t;

endpackage

// File: rtl/drfm_pipe_arbiter_rr_pick.sv
// Combinational round-robin picker: first req after ptr.
// Ports: req (N_CH), ptr (CH_W) -> gnt_idx (CH_W), gnt_any.
module rr_pick
  import drfm_stream_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  int j;

  // Walk from farthest to nearest so the
  // nearest requester after ptr wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = N_CH; k >= 1; k--) begin
      j = (int'(ptr) + k) % N_CH;
      if (req[j]) begin
        gnt_idx = CH_W'(j);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/drfm_pipe_arbiter.sv
// Round-robin burst arbiter feeding the shared DRFM stream pipe.
// Ports: per-channel s_* in, tagged m_* out, busy, trunc_flag/clr.
module drfm_pipe_arbiter
  import drfm_stream_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DATA_W  = 32,
  parameter  int QUANTUM = 64,
  localparam int CH_W    = ch_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH-1:0]        s_valid,
  input  logic [N_CH*DATA_W-1:0] s_data,
  input  logic [N_CH-1:0]        s_last,
  output logic [N_CH-1:0]        s_ready,
  output logic                   m_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_last,
  output logic [CH_W-1:0]        m_ch,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [N_CH-1:0]        trunc_flag,
  input  logic                   trunc_clr
);

  localparam int CNT_W = $clog2(QUANTUM);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(QUANTUM - 1);

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic [CH_W-1:0]   m_ch_q, m_ch_d;
  logic [N_CH-1:0]   trunc_q, trunc_d;

  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;

  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              take;
  logic              accept;
  logic              at_quantum;
  logic              end_burst;

  assign req = s_valid & ch_en;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (owner_q == CH_W'(i)) begin
        own_valid = s_valid[i];
        own_last  = s_last[i];
        own_data  = s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output slot is free when empty or draining.
  assign take       = !m_valid_q || m_ready;
  assign accept     = (state_q == ARB_BURST) &&
                      own_valid && take;
  assign at_quantum = (cnt_q == CNT_MAX);
  assign end_burst  = own_last || at_quantum;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      s_ready[i] = (state_q == ARB_BURST) &&
                   (owner_q == CH_W'(i)) && take;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_ch_d    = m_ch_q;
    trunc_d   = trunc_q;

    if (trunc_clr) begin
      trunc_d = '0;
    end

    if (m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BURST;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = own_data;
          m_last_d  = end_burst;
          m_ch_d    = owner_q;
          if (end_burst) begin
            state_d = ARB_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Set after the clear so set wins.
          if (at_quantum && !own_last) begin
            trunc_d[owner_q] = 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= CH_W'(N_CH - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_ch_q    <= '0;
      trunc_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_ch_q    <= m_ch_d;
      trunc_q   <= trunc_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign m_ch       = m_ch_q;
  assign busy       = (state_q == ARB_BURST);
  assign trunc_flag = trunc_q;

endmodule

// File: tb/tb_drfm_pipe_arbiter.sv
// Directed bench for drfm_pipe_arbiter (N_CH=4, QUANTUM=64).
// Per-channel sources, output log, hand-built expected streams.
module tb_drfm_pipe_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   ch_en;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_last;
  logic [3:0]   s_ready;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_last;
  logic [1:0]   m_ch;
  logic         m_ready;
  logic         busy;
  logic [3:0]   trunc_flag;
  logic         trunc_clr;

  drfm_pipe_arbiter #(
    .N_CH    (4),
    .DATA_W  (32),
    .QUANTUM (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_en      (ch_en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ch       (m_ch),
    .m_ready    (m_ready),
    .busy       (busy),
    .trunc_flag (trunc_flag),
    .trunc_clr  (trunc_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] data;
    logic        last;
    int          cyc;
    logic [3:0]  flag;
  } beat_t;

  beat_t log_q[$];
  beat_t exp_q[$];

  int n_chk;
  int n_fail;
  int cyc;
  int src_len[4];
  int src_sent[4];
  int src_bl[4];
  bit rand_ready;
  bit drop_en1;
  int hold_err;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [1:0]  prev_ch;
  logic        prev_last;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h",
               tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (prev_stall &&
        (!m_valid || m_data != prev_data ||
         m_ch != prev_ch || m_last != prev_last))
      hold_err++;
    m_ready = rand_ready ?
              1'($urandom_range(0, 1)) : 1'b1;
    if (drop_en1 && src_sent[1] >= 6)
      ch_en[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid[i] = src_sent[i] < src_len[i];
      s_data[i*32 +: 32] =
        {8'(i), 24'(src_sent[i])};
      s_last[i] = (src_bl[i] == 0) ? 1'b0 :
        (((src_sent[i] + 1) % src_bl[i]) == 0);
    end
    #1;
    for (int i = 0; i < 4; i++)
      if (s_valid[i] && s_ready[i])
        src_sent[i]++;
    if (m_valid && m_ready)
      log_q.push_back('{m_ch, m_data, m_last,
                        cyc, trunc_flag});
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_ch    = m_ch;
    prev_last  = m_last;
  endtask

  task automatic clr_src();
    for (int i = 0; i < 4; i++) begin
      src_len[i]  = 0;
      src_sent[i] = 0;
      src_bl[i]   = 0;
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_src();
    ch_en    = 4'hF;
    drop_en1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_src(input int ch,
                         input int len,
                         input int bl);
    src_len[ch]  = len;
    src_sent[ch] = 0;
    src_bl[ch]   = bl;
  endtask

  task automatic add_burst(input int ch,
                           input int seq,
                           input int n,
                           input bit last);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.ch   = 2'(ch);
      b.data = {8'(ch), 24'(seq + k)};
      b.last = last && (k == n - 1);
      b.cyc  = 0;
      b.flag = '0;
      exp_q.push_back(b);
    end
  endtask

  task automatic run(input int max,
                     input int want,
                     input int settle);
    int t;
    t = 0;
    while (log_q.size() < want && t < max) begin
      tick();
      t++;
    end
    for (int k = 0; k < settle; k++) tick();
    chk("n_beats", 64'(log_q.size()), 64'(want));
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    n = (log_q.size() < exp_q.size()) ?
        log_q.size() : exp_q.size();
    for (int k = 0; k < n; k++)
      chk(tag,
          64'({log_q[k].ch, log_q[k].data,
               log_q[k].last}),
          64'({exp_q[k].ch, exp_q[k].data,
               exp_q[k].last}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_err;
    n_chk = 0; n_fail = 0; cyc = 0;
    hold_err = 0; prev_stall = 1'b0;
    prev_data = '0; prev_ch = '0; prev_last = 0;
    rand_ready = 1'b0; drop_en1 = 1'b0;
    trunc_clr = 1'b0; m_ready = 1'b1;
    s_valid = '0; s_data = '0; s_last = '0;
    ch_en = 4'hF; rst = 1'b1;
    clr_src();

    // T1: reset with all inputs active
    for (int i = 0; i < 4; i++) set_src(i, 100, 4);
    trunc_clr = 1'b1;
    tick(); tick(); tick();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last",  64'(m_last),  64'd0);
    chk("rst_m_ch",    64'(m_ch),    64'd0);
    chk("rst_m_data",  64'(m_data),  64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_trunc",   64'(trunc_flag), 64'd0);
    trunc_clr = 1'b0;

    // T2: round robin, 4-beat bursts
    clr_src();
    for (int i = 0; i < 4; i++) set_src(i, 8, 4);
    rst = 1'b0;
    for (int b = 0; b < 8; b++)
      add_burst(b % 4, (b / 4) * 4, 4, 1'b1);
    run(300, 32, 5);
    if (log_q.size() > 0)
      chk("first_ch0", 64'(log_q[0].ch), 64'd0);
    cmp_stream("rr_beat");
    gap_err = 0;
    for (int k = 1; k < log_q.size(); k++)
      if (log_q[k].cyc - log_q[k-1].cyc !=
          ((k % 4 == 0) ? 2 : 1))
        gap_err++;
    chk("rr_gap", 64'(gap_err), 64'd0);

    // T3: quantum truncation
    do_reset();
    set_src(1, 100, 0);
    set_src(2, 4, 4);
    add_burst(1, 0, 64, 1'b1);
    add_burst(2, 0, 4, 1'b1);
    add_burst(1, 64, 36, 1'b0);
    run(500, 104, 5);
    cmp_stream("q_beat");
    chk("q_trunc", 64'(trunc_flag), 64'h2);
    chk("q_stall_busy", 64'(busy), 64'd1);
    trunc_clr = 1'b1;
    tick();
    trunc_clr = 1'b0;
    tick();
    chk("q_clr", 64'(trunc_flag), 64'd0);

    // set and clear together: set wins
    do_reset();
    trunc_clr = 1'b1;
    set_src(1, 64, 0);
    add_burst(1, 0, 64, 1'b1);
    run(300, 64, 3);
    cmp_stream("sw_beat");
    if (log_q.size() == 64)
      chk("set_wins", 64'(log_q[63].flag), 64'h2);
    chk("sw_clr_after", 64'(trunc_flag), 64'd0);
    trunc_clr = 1'b0;

    // T4: random backpressure
    do_reset();
    hold_err = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 6, 3);
    for (int b = 0; b < 8; b++)
      add_burst(b % 4, (b / 4) * 3, 3, 1'b1);
    run(600, 24, 5);
    cmp_stream("bp_beat");
    chk("bp_hold", 64'(hold_err), 64'd0);
    rand_ready = 1'b0;

    // T5: channel enables
    do_reset();
    ch_en = 4'b1010;
    drop_en1 = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 12, 4);
    add_burst(1, 0, 4, 1'b1);
    add_burst(3, 0, 4, 1'b1);
    add_burst(1, 4, 4, 1'b1);
    add_burst(3, 4, 4, 1'b1);
    add_burst(3, 8, 4, 1'b1);
    run(400, 20, 8);
    cmp_stream("en_beat");
    chk("en_drop_done", 64'(src_sent[1]), 64'd8);
    chk("en_idle", 64'(busy), 64'd0);
    drop_en1 = 1'b0;

    // T6: reset mid-burst
    do_reset();
    set_src(0, 100, 0);
    set_src(1, 4, 4);
    add_burst(0, 0, 10, 1'b0);
    run(100, 10, 0);
    cmp_stream("mid_beat");
    rst = 1'b1;
    tick();
    chk("mid_m_valid", 64'(m_valid), 64'd0);
    chk("mid_busy",    64'(busy),    64'd0);
    chk("mid_s_ready", 64'(s_ready), 64'd0);
    rst = 1'b0;
    clr_src();
    set_src(0, 4, 4);
    set_src(1, 4, 4);
    add_burst(0, 0, 4, 1'b1);
    add_burst(1, 0, 4, 1'b1);
    run(100, 8, 5);
    cmp_stream("restart_beat");

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
